// File: rtl/idt_clk_programmer.sv
// Serial programming engine for the IDT clock synthesizer: shifts a 24-bit word MSB first, strobes it, reports done.
// Build macro IDT_PROG_LOCK_WAIT_EN adds a LOCK_CYCLES PLL settle wait between the strobe and done.
module idt_clk_programmer #(
    parameter int CLK_DIV     = 4,
    parameter int LOCK_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] cfg_r,
    input  logic [8:0] cfg_v,
    input  logic [2:0] cfg_s,
    input  logic [1:0] cfg_f,
    input  logic       cfg_ttl,
    input  logic [1:0] cfg_c,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       locked,
    output logic       idt_sclk,
    output logic       idt_data,
    output logic       idt_strobe
);

    localparam int STROBE_LEN = 2 * CLK_DIV;
`ifdef IDT_PROG_LOCK_WAIT_EN
    localparam int MAX_CNT = (LOCK_CYCLES > STROBE_LEN) ? LOCK_CYCLES : STROBE_LEN;
`else
    localparam int MAX_CNT = STROBE_LEN;
`endif
    localparam int CW = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_LEN - 1);
`ifdef IDT_PROG_LOCK_WAIT_EN
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
`endif

    if (CLK_DIV < 1 || LOCK_CYCLES < 1) begin : g_param_check
        $error("idt_clk_programmer: CLK_DIV and LOCK_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT_LO,
        S_BIT_HI,
        S_GAP,
        S_STROBE,
`ifdef IDT_PROG_LOCK_WAIT_EN
        S_LOCK_WAIT,
`endif
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    idx, idx_n;
    logic [23:0]   shreg, shreg_n;
    logic          locked_n;
    logic          busy_n, done_n, sclk_n, data_n, strobe_n;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        locked_n = locked;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n  = S_BIT_LO;
                    shreg_n  = {cfg_c, cfg_ttl, cfg_f, cfg_s, cfg_v, cfg_r};
                    idx_n    = 5'd23;
                    locked_n = 1'b0;
                end
            end
            S_BIT_LO: begin
                if (cnt == DIV_LAST) begin
                    state_n = S_BIT_HI;
                    cnt_n   = '0;
                end
            end
            S_BIT_HI: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (idx == 5'd0) begin
                        state_n = S_GAP;
                    end else begin
                        state_n = S_BIT_LO;
                        idx_n   = idx - 5'd1;
                        shreg_n = {shreg[22:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (cnt == DIV_LAST) begin
                    state_n = S_STROBE;
                    cnt_n   = '0;
                end
            end
            S_STROBE: begin
                if (cnt == STROBE_LAST) begin
                    cnt_n = '0;
`ifdef IDT_PROG_LOCK_WAIT_EN
                    state_n = S_LOCK_WAIT;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef IDT_PROG_LOCK_WAIT_EN
            S_LOCK_WAIT: begin
                if (cnt == LOCK_LAST) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (state_n == S_DONE) locked_n = 1'b1;

        // Outputs are decoded from the next state so they can be registered without adding latency.
        busy_n   = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n   = (state_n == S_DONE);
        sclk_n   = (state_n == S_BIT_HI);
        data_n   = ((state_n == S_BIT_LO) || (state_n == S_BIT_HI)) && shreg_n[23];
        strobe_n = (state_n == S_STROBE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            locked     <= locked_n;
            busy       <= busy_n;
            done       <= done_n;
            idt_sclk   <= sclk_n;
            idt_data   <= data_n;
            idt_strobe <= strobe_n;
        end
    end

endmodule

// File: tb/tb_idt_clk_programmer.sv
// Scoreboard bench for idt_clk_programmer: two instances (CLK_DIV=4 and CLK_DIV=1) driven with random
// configuration words; a start-acceptance model predicts each sequence and per-instance monitors check it.
module tb_idt_clk_programmer;

    localparam int N = 2;
`ifdef IDT_PROG_LOCK_WAIT_EN
    localparam int LOCK_EXTRA = 10;
`else
    localparam int LOCK_EXTRA = 0;
`endif

    typedef struct packed {
        logic [1:0] c;
        logic       ttl;
        logic [1:0] f;
        logic [2:0] s;
        logic [8:0] v;
        logic [6:0] r;
    } cfg_t;

    typedef struct {
        logic [23:0] word;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic rst_s   [N];
    logic start_s [N];
    cfg_t cfg_s   [N];
    logic busy_o  [N];
    logic done_o  [N];
    logic lock_o  [N];
    logic sclk_o  [N];
    logic data_o  [N];
    logic strb_o  [N];

    exp_t exp0[$];
    exp_t exp1[$];
    int   nf[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idt_clk_programmer #(.CLK_DIV(4), .LOCK_CYCLES(10)) u_div4 (
        .clk(clk), .reset(rst_s[0]),
        .cfg_r(cfg_s[0].r), .cfg_v(cfg_s[0].v), .cfg_s(cfg_s[0].s),
        .cfg_f(cfg_s[0].f), .cfg_ttl(cfg_s[0].ttl), .cfg_c(cfg_s[0].c),
        .start(start_s[0]),
        .busy(busy_o[0]), .done(done_o[0]), .locked(lock_o[0]),
        .idt_sclk(sclk_o[0]), .idt_data(data_o[0]), .idt_strobe(strb_o[0])
    );

    idt_clk_programmer #(.CLK_DIV(1), .LOCK_CYCLES(10)) u_div1 (
        .clk(clk), .reset(rst_s[1]),
        .cfg_r(cfg_s[1].r), .cfg_v(cfg_s[1].v), .cfg_s(cfg_s[1].s),
        .cfg_f(cfg_s[1].f), .cfg_ttl(cfg_s[1].ttl), .cfg_c(cfg_s[1].c),
        .start(start_s[1]),
        .busy(busy_o[1]), .done(done_o[1]), .locked(lock_o[1]),
        .idt_sclk(sclk_o[1]), .idt_data(data_o[1]), .idt_strobe(strb_o[1])
    );

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // start-to-done edge distance: 48 bit half-periods pairs, gap, strobe, optional settle wait
    function automatic int lat_of(input int u);
        return 48 * div_of(u) + div_of(u) + 2 * div_of(u) + LOCK_EXTRA;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic exp_t qfront(input int u);
        return (u == 0) ? exp0[0] : exp1[0];
    endfunction

    task automatic qpush(input int u, input exp_t e);
        if (u == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic qpop(input int u, output exp_t e);
        if (u == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
    endtask

    task automatic qclear(input int u);
        if (u == 0) exp0.delete();
        else        exp1.delete();
    endtask

    task automatic check(input int u, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", u, name, act, exp, cyc);
        end
    endtask

    function automatic cfg_t rnd_cfg();
        logic [23:0] w;
        w = 24'($urandom());
        return cfg_t'(w);
    endfunction

    // One clock of stimulus; the model decides whether this edge accepts a start.
    task automatic step(input int u, input logic st, input cfg_t c, input logic r);
        int   e;
        exp_t x;
        start_s[u] = st;
        cfg_s[u]   = c;
        rst_s[u]   = r;
        @(posedge clk);
        #1;
        e = cyc;
        if (r) begin
            qclear(u);
            nf[u] = e + 1;
        end else if (st && e >= nf[u]) begin
            x.word = {c.c, c.ttl, c.f, c.s, c.v, c.r};
            x.acc  = e;
            qpush(u, x);
            nf[u] = e + lat_of(u) + 2;
        end
    endtask

    task automatic wait_idle(input int u);
        while (cyc + 1 < nf[u]) step(u, 1'b0, rnd_cfg(), 1'b0);
    endtask

    task automatic check_reset_outs(input int u, input string name);
        check(u, name, 32'({busy_o[u], done_o[u], lock_o[u], sclk_o[u], data_o[u], strb_o[u]}), 32'd0);
    endtask

    task automatic monitor(input int u);
        logic        p_sclk = 1'b0, p_data = 1'b0, p_busy = 1'b0, p_done = 1'b0, p_strb = 1'b0;
        logic [23:0] word = '0;
        int          nbits = 0, nstrb = 0, nruns = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (busy_o[u] === 1'b1 && p_busy !== 1'b1) begin
                word = '0; nbits = 0; nstrb = 0; nruns = 0;
                check(u, "busy_rise_expected", 32'(qsize(u) != 0), 32'd1);
                if (qsize(u) != 0) begin
                    e = qfront(u);
                    check(u, "accept_cycle", 32'(cyc), 32'(e.acc));
                end
                check(u, "locked_cleared", 32'(lock_o[u]), 32'd0);
            end
            if (sclk_o[u] === 1'b1 && p_sclk !== 1'b1) begin
                word = {word[22:0], data_o[u]};
                nbits++;
                check(u, "data_stable_at_rise", 32'(data_o[u]), 32'(p_data));
            end
            if (strb_o[u] === 1'b1) begin
                nstrb++;
                if (p_strb !== 1'b1) nruns++;
                check(u, "strobe_sclk_data_low", 32'({sclk_o[u], data_o[u]}), 32'd0);
            end
            if (done_o[u] === 1'b1) begin
                check(u, "done_expected", 32'(qsize(u) != 0), 32'd1);
                if (qsize(u) != 0) begin
                    qpop(u, e);
                    check(u, "word", 32'(word), 32'(e.word));
                    check(u, "sclk_edges", 32'(nbits), 32'd24);
                    check(u, "strobe_len", 32'(nstrb), 32'(2 * div_of(u)));
                    check(u, "strobe_runs", 32'(nruns), 32'd1);
                    check(u, "done_latency", 32'(cyc - e.acc), 32'(lat_of(u)));
                end
                check(u, "locked_at_done", 32'(lock_o[u]), 32'd1);
                check(u, "busy_at_done", 32'(busy_o[u]), 32'd0);
                check(u, "done_single", 32'(p_done), 32'd0);
            end
            p_sclk = sclk_o[u];
            p_data = data_o[u];
            p_busy = busy_o[u];
            p_done = done_o[u];
            p_strb = strb_o[u];
        end
    endtask

    task automatic run_unit0();
        cfg_t d;
        d = '{c: 2'd0, ttl: 1'b1, f: 2'd2, s: 3'd1, v: 9'd41, r: 7'd31};
        repeat (3) step(0, 1'b0, rnd_cfg(), 1'b1);
        check_reset_outs(0, "reset_state");

        // directed word 0x31149F, with a second start mid-shift that must be ignored
        step(0, 1'b1, d, 1'b0);
        repeat (48) step(0, 1'b0, rnd_cfg(), 1'b0);
        step(0, 1'b1, rnd_cfg(), 1'b0);
        wait_idle(0);

        d.v = 9'd0;
        step(0, 1'b1, d, 1'b0);
        wait_idle(0);

        // reset mid-shift, then a full sequence
        step(0, 1'b1, rnd_cfg(), 1'b0);
        repeat (98) step(0, 1'b0, rnd_cfg(), 1'b0);
        step(0, 1'b0, rnd_cfg(), 1'b1);
        check_reset_outs(0, "mid_seq_reset");
        step(0, 1'b1, rnd_cfg(), 1'b0);
        wait_idle(0);

        // start held high: back-to-back sequences
        repeat (3 * (lat_of(0) + 2) + 5) step(0, 1'b1, rnd_cfg(), 1'b0);
        step(0, 1'b0, rnd_cfg(), 1'b0);
        wait_idle(0);

        repeat (800) step(0, 1'($urandom_range(0, 15) == 0), rnd_cfg(), 1'b0);
        step(0, 1'b0, rnd_cfg(), 1'b0);
        wait_idle(0);
    endtask

    task automatic run_unit1();
        repeat (2) step(1, 1'b0, rnd_cfg(), 1'b1);
        check_reset_outs(1, "reset_state");
        repeat (5) begin
            step(1, 1'b1, rnd_cfg(), 1'b0);
            wait_idle(1);
            repeat ($urandom_range(0, 3)) step(1, 1'b0, rnd_cfg(), 1'b0);
        end
        repeat (300) step(1, 1'($urandom_range(0, 3) == 0), rnd_cfg(), 1'b0);
        step(1, 1'b0, rnd_cfg(), 1'b0);
        wait_idle(1);
    endtask

    initial begin
        for (int u = 0; u < N; u++) begin
            rst_s[u]   = 1'b1;
            start_s[u] = 1'b0;
            cfg_s[u]   = '0;
            nf[u]      = 0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        fork
            run_unit0();
            run_unit1();
        join
        for (int u = 0; u < N; u++) begin
            int guard = 0;
            while (qsize(u) != 0 && guard < 3000) begin
                @(posedge clk);
                guard++;
            end
            check(u, "scoreboard_drained", 32'(qsize(u)), 32'd0);
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
